// File: rtl/dap_swd_xfer_ctrl.sv
// rtl/dap_swd_xfer_ctrl.sv - SWD single-transfer controller with WAIT retry
//
// Takes one SWD register transfer request at a time, issues it to the SWD
// sequencer as a transfer command, retries on WAIT acks up to cfg_wait_retry
// times, and returns one response per request.
//
// Ports:
//   clk, resetn                    controller clock, async active-low reset
//   cfg_wait_retry                 max extra attempts after a WAIT ack
//   req_valid/req_ready            request handshake
//   req_apndp, req_rnw, req_addr,
//   req_wdata                      request fields (A[3:2] in req_addr)
//   rsp_valid/rsp_ready            response handshake
//   rsp_ack, rsp_rdata,
//   rsp_retries                    final ack, read data, WAIT retries used
//   seq_tx_valid, seq_tx_cmd,
//   seq_tx_data, seq_tx_full       command level interface to the sequencer
//   seq_rx_valid, seq_rx_flag,
//   seq_rx_data                    completion level interface from the sequencer
//
// Optional build macro DAP_XFER_MATCH_EN adds read-compare with reissue:
//   req_match, cfg_match_mask, cfg_match_retry inputs, rsp_mismatch output.

`ifndef SEQ_CMD_SWD_TRANSFER
`define SEQ_CMD_SWD_TRANSFER 4'h3
`endif

module dap_swd_xfer_ctrl #(
    parameter int GAP_CYCLES = 8,
    parameter int RETRY_W    = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [RETRY_W-1:0] cfg_wait_retry,
`ifdef DAP_XFER_MATCH_EN
    input  logic               req_match,
    input  logic [31:0]        cfg_match_mask,
    input  logic [RETRY_W-1:0] cfg_match_retry,
    output logic               rsp_mismatch,
`endif
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_apndp,
    input  logic               req_rnw,
    input  logic [1:0]         req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2:0]         rsp_ack,
    output logic [31:0]        rsp_rdata,
    output logic [RETRY_W-1:0] rsp_retries,
    output logic               seq_tx_valid,
    output logic [15:0]        seq_tx_cmd,
    output logic [63:0]        seq_tx_data,
    input  logic               seq_tx_full,
    input  logic               seq_rx_valid,
    input  logic [15:0]        seq_rx_flag,
    input  logic [63:0]        seq_rx_data
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0] ACK_OK   = 3'b001;
    localparam logic [2:0] ACK_WAIT = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_ISSUE,
        ST_DECIDE,
        ST_RESP
    } state_t;

    state_t state, state_nxt;

    logic [GAP_W-1:0]   gap_cnt;
    logic [RETRY_W-1:0] retry_cnt;
    logic               lat_apndp;
    logic               lat_rnw;
    logic [1:0]         lat_addr;
    logic [31:0]        lat_wdata;
    logic               rx_prev;
    logic [2:0]         cap_ack;
    logic [31:0]        cap_data;
    logic               req_ready_d;
    logic               seq_tx_valid_d;
    logic               rsp_valid_d;
    logic               accept;
    logic               rx_rise;
    logic               wait_retry;
    logic               match_retry;

    // Upper flag/data bits carry nothing for a register transfer.
    logic unused_rx_bits;
    assign unused_rx_bits = &{1'b0, seq_rx_flag[15:3], seq_rx_data[63:32]};

    assign accept     = (state == ST_IDLE) && req_valid && req_ready;
    assign rx_rise    = seq_rx_valid && !rx_prev;
    // An all-ones counter can never be below the limit, so it saturates here.
    assign wait_retry = (cap_ack == ACK_WAIT) && (retry_cnt < cfg_wait_retry);

`ifdef DAP_XFER_MATCH_EN
    logic               lat_match;
    logic [RETRY_W-1:0] match_cnt;
    logic               cmp_fail;
    assign cmp_fail    = lat_match && lat_rnw && (cap_ack == ACK_OK) &&
                         (((cap_data ^ lat_wdata) & cfg_match_mask) != 32'd0);
    assign match_retry = cmp_fail && (match_cnt < cfg_match_retry);
`else
    assign match_retry = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_GAP;
            // Sequencer completion must be low again so its next edge is fresh.
            ST_GAP:    if ((gap_cnt == '0) && !seq_rx_valid && !seq_tx_full)
                           state_nxt = ST_ISSUE;
            ST_ISSUE:  if (rx_rise) state_nxt = ST_DECIDE;
            ST_DECIDE: state_nxt = (wait_retry || match_retry) ? ST_GAP : ST_RESP;
            ST_RESP:   if (rsp_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; handshake outputs are registered from the next state so
    // they are glitch-free and read 0 while in reset.
    always_comb begin
        req_ready_d    = (state_nxt == ST_IDLE);
        seq_tx_valid_d = (state_nxt == ST_ISSUE);
        rsp_valid_d    = (state_nxt == ST_RESP);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_ready    <= 1'b0;
            seq_tx_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            seq_tx_cmd   <= '0;
            seq_tx_data  <= '0;
            rsp_ack      <= '0;
            rsp_rdata    <= '0;
            rsp_retries  <= '0;
            gap_cnt      <= '0;
            retry_cnt    <= '0;
            lat_apndp    <= 1'b0;
            lat_rnw      <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rx_prev      <= 1'b0;
            cap_ack      <= '0;
            cap_data     <= '0;
`ifdef DAP_XFER_MATCH_EN
            lat_match    <= 1'b0;
            match_cnt    <= '0;
            rsp_mismatch <= 1'b0;
`endif
        end else begin
            req_ready    <= req_ready_d;
            seq_tx_valid <= seq_tx_valid_d;
            rsp_valid    <= rsp_valid_d;
            rx_prev      <= seq_rx_valid;

            if (accept) begin
                lat_apndp <= req_apndp;
                lat_rnw   <= req_rnw;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                retry_cnt <= '0;
`ifdef DAP_XFER_MATCH_EN
                lat_match <= req_match;
                match_cnt <= '0;
`endif
            end

            if ((state_nxt == ST_GAP) && (state != ST_GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end

            // Command is loaded once on entry and held for the whole ISSUE.
            if ((state_nxt == ST_ISSUE) && (state != ST_ISSUE)) begin
                seq_tx_cmd  <= {`SEQ_CMD_SWD_TRANSFER, 8'd0, lat_addr, lat_rnw, lat_apndp};
                seq_tx_data <= {32'd0, lat_wdata};
            end

            if ((state == ST_ISSUE) && rx_rise) begin
                cap_ack  <= seq_rx_flag[2:0];
                cap_data <= seq_rx_data[31:0];
            end

            if (state == ST_DECIDE) begin
                if (wait_retry) begin
                    retry_cnt <= retry_cnt + 1'b1;
`ifdef DAP_XFER_MATCH_EN
                end else if (match_retry) begin
                    retry_cnt <= '0;
                    match_cnt <= match_cnt + 1'b1;
`endif
                end else begin
                    rsp_ack     <= cap_ack;
                    rsp_rdata   <= ((cap_ack == ACK_OK) && lat_rnw) ? cap_data : 32'd0;
                    rsp_retries <= retry_cnt;
`ifdef DAP_XFER_MATCH_EN
                    rsp_mismatch <= cmp_fail;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_dap_swd_xfer_ctrl.sv
// tb/tb_dap_swd_xfer_ctrl.sv - self-checking bench for dap_swd_xfer_ctrl

`ifndef SEQ_CMD_SWD_TRANSFER
`define SEQ_CMD_SWD_TRANSFER 4'h3
`endif

module tb_dap_swd_xfer_ctrl;

    localparam int GAP = 8;
    localparam logic [3:0] OPC = `SEQ_CMD_SWD_TRANSFER;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] cfg_wait_retry;
    logic        req_valid, req_ready, req_apndp, req_rnw;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic [15:0] rsp_retries;
    logic        seq_tx_valid, seq_tx_full, seq_rx_valid;
    logic [15:0] seq_tx_cmd, seq_rx_flag;
    logic [63:0] seq_tx_data, seq_rx_data;
`ifdef DAP_XFER_MATCH_EN
    logic        req_match;
    logic [31:0] cfg_match_mask;
    logic [15:0] cfg_match_retry;
    logic        rsp_mismatch;
`endif

    always #5 clk = ~clk;

    dap_swd_xfer_ctrl #(.GAP_CYCLES(GAP), .RETRY_W(16)) dut (
        .clk(clk), .resetn(resetn), .cfg_wait_retry(cfg_wait_retry),
`ifdef DAP_XFER_MATCH_EN
        .req_match(req_match), .cfg_match_mask(cfg_match_mask),
        .cfg_match_retry(cfg_match_retry), .rsp_mismatch(rsp_mismatch),
`endif
        .req_valid(req_valid), .req_ready(req_ready), .req_apndp(req_apndp),
        .req_rnw(req_rnw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
        .rsp_rdata(rsp_rdata), .rsp_retries(rsp_retries),
        .seq_tx_valid(seq_tx_valid), .seq_tx_cmd(seq_tx_cmd), .seq_tx_data(seq_tx_data),
        .seq_tx_full(seq_tx_full), .seq_rx_valid(seq_rx_valid),
        .seq_rx_flag(seq_rx_flag), .seq_rx_data(seq_rx_data)
    );

    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic [15:0] retries;
        logic        mism;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    rsp_t        rsp_q[$];
    logic [34:0] ack_q[$];
    int          cmd_count = 0;
    int          low_cnt = 0;
    logic [15:0] exp_cmd;
    logic [31:0] exp_wdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sequencer model: checks each issued command and answers from ack_q
    // a few cycles later; no answer when ack_q is empty.
    initial begin : seq_model
        logic prev_tx;
        int   delay;
        bit   pending;
        logic [34:0] e;
        prev_tx = 1'b0; pending = 0; delay = 0;
        seq_rx_valid = 1'b0;
        seq_rx_flag  = '0;
        seq_rx_data  = '0;
        forever begin
            @(negedge clk);
            if (seq_tx_valid && !prev_tx) begin
                cmd_count++;
                chk("tx_gap_ge_gap_cycles", 64'(low_cnt >= GAP), 64'd1);
                chk("tx_cmd", seq_tx_cmd, exp_cmd);
                chk("tx_data", seq_tx_data, {32'd0, exp_wdata});
                low_cnt = 0;
                if (ack_q.size() > 0) begin
                    pending = 1;
                    delay = 3;
                end
            end else if (!seq_tx_valid) begin
                low_cnt++;
            end
            if (!seq_tx_valid && seq_rx_valid) seq_rx_valid = 1'b0;
            if (pending) begin
                if (delay == 0) begin
                    e = ack_q.pop_front();
                    seq_rx_flag  = {13'h1FFF & 13'h0A5A, e[34:32]};
                    seq_rx_data  = {32'hA5A5_5A5A, e[31:0]};
                    seq_rx_valid = 1'b1;
                    pending = 0;
                end else begin
                    delay--;
                end
            end
            prev_tx = seq_tx_valid;
        end
    end

    task automatic send_req(input logic apndp, input logic rnw, input logic [1:0] addr,
                            input logic [31:0] wdata, input logic match, output bit ok);
        exp_cmd   = {OPC, 8'd0, addr, rnw, apndp};
        exp_wdata = wdata;
        req_apndp = apndp;
        req_rnw   = rnw;
        req_addr  = addr;
        req_wdata = wdata;
`ifdef DAP_XFER_MATCH_EN
        req_match = match;
`else
        if (match) exp_wdata = wdata;
`endif
        req_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        chk("req_accepted", 64'(ok), 64'd1);
    endtask

    task automatic do_xfer(input logic apndp, input logic rnw, input logic [1:0] addr,
                           input logic [31:0] wdata, input logic match,
                           input logic [2:0] e_ack, input logic [31:0] e_rdata,
                           input logic [15:0] e_ret, input logic e_mism, input int e_cmds);
        rsp_t r;
        int   start;
        bit   ok;
        r.ack = e_ack; r.rdata = e_rdata; r.retries = e_ret; r.mism = e_mism;
        rsp_q.push_back(r);
        start = cmd_count;
        @(negedge clk);
        send_req(apndp, rnw, addr, wdata, match, ok);
        ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1;
        end
        chk("rsp_valid_seen", 64'(ok), 64'd1);
        r = rsp_q.pop_front();
        if (ok) begin
            chk("rsp_ack", 64'(rsp_ack), 64'(r.ack));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
            chk("rsp_retries", 64'(rsp_retries), 64'(r.retries));
`ifdef DAP_XFER_MATCH_EN
            chk("rsp_mismatch", 64'(rsp_mismatch), 64'(r.mism));
`endif
            chk("cmd_count", 64'(cmd_count - start), 64'(e_cmds));
            @(negedge clk);
            chk("rsp_held", 64'({rsp_valid, rsp_ack}), 64'({1'b1, r.ack}));
            rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("rsp_valid_fall", 64'(rsp_valid), 64'd0);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_tx_valid", 64'(seq_tx_valid), 64'd0);
        chk("rst_tx_cmd", 64'(seq_tx_cmd), 64'd0);
        chk("rst_tx_data", seq_tx_data, 64'd0);
        chk("rst_rsp_ack", 64'(rsp_ack), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_retries", 64'(rsp_retries), 64'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int  bad;
        bit  ok;
        resetn = 1'b0;
        cfg_wait_retry = 16'd3;
        req_valid = 1'b0; req_apndp = 1'b0; req_rnw = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; seq_tx_full = 1'b0;
        exp_cmd = '0; exp_wdata = '0;
`ifdef DAP_XFER_MATCH_EN
        req_match = 1'b0; cfg_match_mask = '0; cfg_match_retry = '0;
`endif
        repeat (3) @(negedge clk);
        chk_reset_vals();
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 64'(req_ready), 64'd1);

        // DP read addr 0, OK
        ack_q.push_back({3'b001, 32'h2BA0_1477});
        do_xfer(1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 3'b001, 32'h2BA0_1477, 16'd0, 1'b0, 1);

        // AP write A=01, WAIT WAIT OK
        cfg_wait_retry = 16'd3;
        ack_q.push_back({3'b010, 32'hFFFF_0000});
        ack_q.push_back({3'b010, 32'hFFFF_0000});
        ack_q.push_back({3'b001, 32'hFFFF_0000});
        do_xfer(1'b1, 1'b0, 2'b01, 32'hDEAD_BEEF, 1'b0, 3'b001, 32'h0, 16'd2, 1'b0, 3);

        // Retry limit 1, always WAIT
        cfg_wait_retry = 16'd1;
        ack_q.push_back({3'b010, 32'h1111_1111});
        ack_q.push_back({3'b010, 32'h1111_1111});
        do_xfer(1'b1, 1'b1, 2'b11, 32'h0, 1'b0, 3'b010, 32'h0, 16'd1, 1'b0, 2);

        // Retry limit 0 returns WAIT at once
        cfg_wait_retry = 16'd0;
        ack_q.push_back({3'b010, 32'h2222_2222});
        do_xfer(1'b0, 1'b1, 2'b10, 32'h0, 1'b0, 3'b010, 32'h0, 16'd0, 1'b0, 1);

        // Protocol error, FAULT and unknown acks: no retry, rdata zero
        cfg_wait_retry = 16'd3;
        ack_q.push_back({3'b111, 32'h1234_5678});
        do_xfer(1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 3'b111, 32'h0, 16'd0, 1'b0, 1);
        ack_q.push_back({3'b100, 32'h1234_5678});
        do_xfer(1'b0, 1'b1, 2'b01, 32'h0, 1'b0, 3'b100, 32'h0, 16'd0, 1'b0, 1);
        ack_q.push_back({3'b011, 32'h1234_5678});
        do_xfer(1'b1, 1'b1, 2'b10, 32'h0, 1'b0, 3'b011, 32'h0, 16'd0, 1'b0, 1);

        // WAIT then OK read returns data and retry count 1
        ack_q.push_back({3'b010, 32'h0});
        ack_q.push_back({3'b001, 32'hCAFE_F00D});
        do_xfer(1'b1, 1'b1, 2'b11, 32'h0, 1'b0, 3'b001, 32'hCAFE_F00D, 16'd1, 1'b0, 2);

`ifdef DAP_XFER_MATCH_EN
        cfg_match_mask = 32'h1;
        cfg_match_retry = 16'd2;
        ack_q.push_back({3'b001, 32'h0});
        ack_q.push_back({3'b001, 32'h0});
        ack_q.push_back({3'b001, 32'h1});
        do_xfer(1'b1, 1'b1, 2'b00, 32'h1, 1'b1, 3'b001, 32'h1, 16'd0, 1'b0, 3);
        ack_q.push_back({3'b001, 32'h0});
        ack_q.push_back({3'b001, 32'h0});
        ack_q.push_back({3'b001, 32'h0});
        do_xfer(1'b1, 1'b1, 2'b00, 32'h1, 1'b1, 3'b001, 32'h0, 16'd0, 1'b1, 3);
`endif

        // seq_tx_full holds the command back, then reset during ISSUE
        seq_tx_full = 1'b1;
        @(negedge clk);
        send_req(1'b0, 1'b1, 2'b10, 32'h0, 1'b0, ok);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (seq_tx_valid) bad++;
        end
        chk("tx_low_while_full", 64'(bad), 64'd0);
        seq_tx_full = 1'b0;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (seq_tx_valid) ok = 1;
        end
        chk("tx_after_full_falls", 64'(ok), 64'd1);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk_reset_vals();
        @(negedge clk);
        resetn = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) bad++;
        end
        chk("no_rsp_after_reset", 64'(bad), 64'd0);
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
